// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the accumulator-machine control unit: FSM state
// encoding, opcode field constants, datapath select encodings and the packed
// control-output vector produced by the decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package cu_pkg;

  // FSM states. Codes 11..15 are unused and recover to S_FETCH1.
  typedef enum logic [3:0] {
    S_FETCH1   = 4'd0,
    S_FETCH2   = 4'd1,
    S_ALU_SRC  = 4'd2,
    S_ALU_EXEC = 4'd3,
    S_ALU_WB   = 4'd4,
    S_SETD     = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LD_WB    = 4'd7,
    S_ST_RD    = 4'd8,
    S_ST_WR    = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  // Opcode fields: bit 3 set selects an ALU op, otherwise op[3:1] is the class.
  localparam int         OPC_ALU_BIT = 3;
  localparam logic [2:0] OPC_LOAD    = 3'b000;
  localparam logic [2:0] OPC_STORE   = 3'b001;
  localparam logic [2:0] OPC_JMP     = 3'b010;
  localparam logic [2:0] OPC_SETD    = 3'b011;

  // Datapath select encodings.
  localparam logic       SELADDR_PC   = 1'b0;
  localparam logic       SELADDR_RI   = 1'b1;
  localparam logic       SELPC_INC    = 1'b0;
  localparam logic       SELPC_RI     = 1'b1;
  localparam logic [1:0] SELAC_DI     = 2'd0;
  localparam logic [1:0] SELAC_LS_LO  = 2'd1;
  localparam logic [1:0] SELAC_LS_HI  = 2'd2;
  localparam logic [1:0] SELDAT_WORD  = 2'd0;
  localparam logic [1:0] SELDAT_RES   = 2'd1;
  localparam logic [1:0] SELDAT_DATA  = 2'd2;
  localparam logic       SELALU_DATA  = 1'b0;
  localparam logic       SELALU_WORD  = 1'b1;

  // Complete set of control outputs for one cycle.
  typedef struct packed {
    logic       pcEn;
    logic       selPC;
    logic       selAddress;
    logic       mr;
    logic       mw;
    logic       wordRegEn;
    logic       LSEn;
    logic       RSEn;
    logic       DIEn;
    logic       selALUsrc;
    logic       enb;
    logic       dataRegEn;
    logic       resultRegEn;
    logic       CEn;
    logic       ZEn;
    logic       NEn;
    logic [1:0] selAddressAC;
    logic [1:0] selData;
    logic [2:0] operation;
    logic       instrDone;
  } cu_ctrl_t;

  localparam cu_ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cu_if.sv
// -----------------------------------------------------------------------------
// cu_if
// Bundle between the control unit and the datapath.
//   toCU          : opcode nibble from memory output bits [7:4]
//   pcEn..NEn     : 1-bit datapath strobes and selects
//   selAddressAC  : AC index select, selData : AC write-data select
//   operation     : ALU function, instrDone : last-state pulse
// Modports: master = control unit, slave = datapath.
// -----------------------------------------------------------------------------
interface cu_if;
  logic [3:0] toCU;
  logic       pcEn;
  logic       selPC;
  logic       selAddress;
  logic       mr;
  logic       mw;
  logic       wordRegEn;
  logic       LSEn;
  logic       RSEn;
  logic       DIEn;
  logic       selALUsrc;
  logic       enb;
  logic       dataRegEn;
  logic       resultRegEn;
  logic       CEn;
  logic       ZEn;
  logic       NEn;
  logic [1:0] selAddressAC;
  logic [1:0] selData;
  logic [2:0] operation;
  logic       instrDone;

  modport master (
    input  toCU,
    output pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn,
           selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn,
           selAddressAC, selData, operation, instrDone
  );

  modport slave (
    output toCU,
    input  pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn,
           selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn,
           selAddressAC, selData, operation, instrDone
  );
endinterface

// File: rtl/cu_decode.sv
// -----------------------------------------------------------------------------
// cu_decode
// Purely combinational Moore output decode: state + latched ALU function to
// the full control vector. Anything not set for a state stays 0.
//   i_state  : current FSM state
//   i_alu_fn : latched op[2:0], forwarded to the ALU in ALU_EXEC
//   o_ctrl   : control vector
// -----------------------------------------------------------------------------
module cu_decode
  import cu_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_alu_fn,
  output cu_ctrl_t   o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      S_FETCH1: begin
        o_ctrl.selAddress = SELADDR_PC;
        o_ctrl.mr         = 1'b1;
        o_ctrl.LSEn       = 1'b1;
        o_ctrl.pcEn       = 1'b1;
      end
      S_FETCH2: begin
        o_ctrl.selAddress = SELADDR_PC;
        o_ctrl.mr         = 1'b1;
        o_ctrl.RSEn       = 1'b1;
        o_ctrl.pcEn       = 1'b1;
      end
      S_ALU_SRC: begin
        o_ctrl.selAddressAC = SELAC_LS_HI;
        o_ctrl.dataRegEn    = 1'b1;
      end
      S_ALU_EXEC: begin
        o_ctrl.selAddressAC = SELAC_LS_LO;
        o_ctrl.selALUsrc    = SELALU_DATA;
        o_ctrl.operation    = i_alu_fn;
        o_ctrl.resultRegEn  = 1'b1;
        o_ctrl.CEn          = 1'b1;
        o_ctrl.ZEn          = 1'b1;
        o_ctrl.NEn          = 1'b1;
      end
      S_ALU_WB: begin
        o_ctrl.selAddressAC = SELAC_LS_LO;
        o_ctrl.selData      = SELDAT_RES;
        o_ctrl.enb          = 1'b1;
        o_ctrl.instrDone    = 1'b1;
      end
      S_SETD: begin
        o_ctrl.DIEn      = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      S_MEM_RD: begin
        o_ctrl.selAddress = SELADDR_RI;
        o_ctrl.mr         = 1'b1;
        o_ctrl.wordRegEn  = 1'b1;
      end
      S_LD_WB: begin
        o_ctrl.selAddressAC = SELAC_DI;
        o_ctrl.selData      = SELDAT_WORD;
        o_ctrl.enb          = 1'b1;
        o_ctrl.instrDone    = 1'b1;
      end
      S_ST_RD: begin
        o_ctrl.selAddressAC = SELAC_DI;
        o_ctrl.dataRegEn    = 1'b1;
      end
      S_ST_WR: begin
        o_ctrl.selAddress = SELADDR_RI;
        o_ctrl.mw         = 1'b1;
        o_ctrl.instrDone  = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.selPC     = SELPC_RI;
        o_ctrl.pcEn      = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Moore FSM sequencing fetch/execute for the accumulator machine.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; forces FETCH1, op=0, all outputs 0
//   bus   : cu_if.master -- toCU opcode in, datapath strobes/selects out
// The opcode is latched only in FETCH1; the FETCH1 branch looks at toCU
// directly because op is being loaded on that same edge.
// -----------------------------------------------------------------------------
module control_unit
  import cu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  cu_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  cu_ctrl_t   w_ctrl;
  cu_ctrl_t   w_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH1;
      r_op    <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH1) r_op <= bus.toCU;
    end
  end

  always_comb begin
    w_next = S_FETCH1;
    case (r_state)
      S_FETCH1: begin
        if (bus.toCU[OPC_ALU_BIT])          w_next = S_ALU_SRC;
        else if (bus.toCU[3:1] == OPC_SETD) w_next = S_SETD;
        else                                w_next = S_FETCH2;
      end
      S_FETCH2: begin
        case (r_op[3:1])
          OPC_LOAD:  w_next = S_MEM_RD;
          OPC_STORE: w_next = S_ST_RD;
          OPC_JMP:   w_next = S_JUMP;
          default:   w_next = S_FETCH1;
        endcase
      end
      S_ALU_SRC:  w_next = S_ALU_EXEC;
      S_ALU_EXEC: w_next = S_ALU_WB;
      S_MEM_RD:   w_next = S_LD_WB;
      S_ST_RD:    w_next = S_ST_WR;
      default:    w_next = S_FETCH1;
    endcase
  end

  cu_decode u_decode (
    .i_state  (r_state),
    .i_alu_fn (r_op[2:0]),
    .o_ctrl   (w_ctrl)
  );

  // FETCH1 decodes to active strobes, so reset must mask outputs directly
  // rather than rely on the state register alone.
  assign w_out = reset ? CTRL_IDLE : w_ctrl;

  assign bus.pcEn         = w_out.pcEn;
  assign bus.selPC        = w_out.selPC;
  assign bus.selAddress   = w_out.selAddress;
  assign bus.mr           = w_out.mr;
  assign bus.mw           = w_out.mw;
  assign bus.wordRegEn    = w_out.wordRegEn;
  assign bus.LSEn         = w_out.LSEn;
  assign bus.RSEn         = w_out.RSEn;
  assign bus.DIEn         = w_out.DIEn;
  assign bus.selALUsrc    = w_out.selALUsrc;
  assign bus.enb          = w_out.enb;
  assign bus.dataRegEn    = w_out.dataRegEn;
  assign bus.resultRegEn  = w_out.resultRegEn;
  assign bus.CEn          = w_out.CEn;
  assign bus.ZEn          = w_out.ZEn;
  assign bus.NEn          = w_out.NEn;
  assign bus.selAddressAC = w_out.selAddressAC;
  assign bus.selData      = w_out.selData;
  assign bus.operation    = w_out.operation;
  assign bus.instrDone    = w_out.instrDone;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench: each instruction's expected per-cycle output sequence is
// queued when its opcode is presented, then popped and compared each cycle.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic clk = 1'b0;
  logic reset;

  cu_if bus ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcEn;
    logic       selPC;
    logic       selAddress;
    logic       mr;
    logic       mw;
    logic       wordRegEn;
    logic       LSEn;
    logic       RSEn;
    logic       DIEn;
    logic       selALUsrc;
    logic       enb;
    logic       dataRegEn;
    logic       resultRegEn;
    logic       CEn;
    logic       ZEn;
    logic       NEn;
    logic [1:0] selAddressAC;
    logic [1:0] selData;
    logic [2:0] operation;
    logic       instrDone;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_f1   = 0;
  int   n_cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t observe();
    vec_t v;
    v.pcEn         = bus.pcEn;
    v.selPC        = bus.selPC;
    v.selAddress   = bus.selAddress;
    v.mr           = bus.mr;
    v.mw           = bus.mw;
    v.wordRegEn    = bus.wordRegEn;
    v.LSEn         = bus.LSEn;
    v.RSEn         = bus.RSEn;
    v.DIEn         = bus.DIEn;
    v.selALUsrc    = bus.selALUsrc;
    v.enb          = bus.enb;
    v.dataRegEn    = bus.dataRegEn;
    v.resultRegEn  = bus.resultRegEn;
    v.CEn          = bus.CEn;
    v.ZEn          = bus.ZEn;
    v.NEn          = bus.NEn;
    v.selAddressAC = bus.selAddressAC;
    v.selData      = bus.selData;
    v.operation    = bus.operation;
    v.instrDone    = bus.instrDone;
    return v;
  endfunction

  function automatic vec_t v_fetch1();
    vec_t v = '0;
    v.mr = 1'b1; v.LSEn = 1'b1; v.pcEn = 1'b1;
    return v;
  endfunction

  // Expected cycle-by-cycle outputs of one whole instruction.
  task automatic push_expected(input logic [3:0] opc);
    vec_t v;
    exp_q.push_back(v_fetch1());
    if (opc[3]) begin
      v = '0; v.selAddressAC = 2'd2; v.dataRegEn = 1'b1;
      exp_q.push_back(v);
      v = '0; v.selAddressAC = 2'd1; v.operation = opc[2:0];
      v.resultRegEn = 1'b1; v.CEn = 1'b1; v.ZEn = 1'b1; v.NEn = 1'b1;
      exp_q.push_back(v);
      v = '0; v.selAddressAC = 2'd1; v.selData = 2'd1; v.enb = 1'b1; v.instrDone = 1'b1;
      exp_q.push_back(v);
    end else if (opc[2:1] == 2'b11) begin
      v = '0; v.DIEn = 1'b1; v.instrDone = 1'b1;
      exp_q.push_back(v);
    end else begin
      v = '0; v.mr = 1'b1; v.RSEn = 1'b1; v.pcEn = 1'b1;
      exp_q.push_back(v);
      case (opc[2:1])
        2'b00: begin
          v = '0; v.selAddress = 1'b1; v.mr = 1'b1; v.wordRegEn = 1'b1;
          exp_q.push_back(v);
          v = '0; v.enb = 1'b1; v.instrDone = 1'b1;
          exp_q.push_back(v);
        end
        2'b01: begin
          v = '0; v.dataRegEn = 1'b1;
          exp_q.push_back(v);
          v = '0; v.selAddress = 1'b1; v.mw = 1'b1; v.instrDone = 1'b1;
          exp_q.push_back(v);
        end
        default: begin
          v = '0; v.selPC = 1'b1; v.pcEn = 1'b1; v.instrDone = 1'b1;
          exp_q.push_back(v);
        end
      endcase
    end
  endtask

  // Compare one cycle against the scoreboard head, plus per-cycle invariants.
  task automatic step_check(input string tag);
    vec_t o;
    vec_t e;
    o = observe();
    e = exp_q.pop_front();
    chk(tag, 32'(o), 32'(e));
    chk("mr_and_mw", 32'(o.mr & o.mw), 32'd0);
    chk("ls_rs_word_multi", 32'($countones({o.LSEn, o.RSEn, o.wordRegEn}) > 1), 32'd0);
    if (o.instrDone) n_done++;
    if (o.mr && o.LSEn) n_f1++;
    n_cyc++;
  endtask

  // Present opcode in FETCH1, then scramble toCU for the rest of the
  // instruction so any late re-latch of op shows up in the outputs.
  task automatic run_instr(input logic [3:0] opc, input bit scramble);
    int k;
    bus.toCU = opc;
    push_expected(opc);
    k = 0;
    while (exp_q.size() > 0) begin
      step_check($sformatf("op%h_c%0d", opc, k));
      @(negedge clk);
      if (scramble) bus.toCU = 4'($urandom_range(0, 15));
      k++;
    end
  endtask

  initial begin
    int d0;
    int f0;
    int c0;
    vec_t o;

    reset    = 1'b1;
    bus.toCU = 4'b0000;
    #2;
    chk("reset_out_t0", 32'(observe()), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_out_clk", 32'(observe()), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_f1", 32'(observe()), 32'(v_fetch1()));

    // Directed: ALU 1010, LOAD, STORE, JMP then SETD.
    run_instr(4'b1010, 1'b1);
    run_instr(4'b0000, 1'b1);
    run_instr(4'b0010, 1'b1);
    d0 = n_done;
    run_instr(4'b0100, 1'b1);
    run_instr(4'b0110, 1'b1);
    chk("jmp_setd_done_cnt", 32'(n_done - d0), 32'd2);

    // Every opcode once, in order.
    for (int i = 0; i < 16; i++) run_instr(4'(i), 1'b1);

    // Reset arriving in ALU_EXEC.
    bus.toCU = 4'b1010;
    push_expected(4'b1010);
    step_check("midrst_f1");
    @(negedge clk);
    bus.toCU = 4'b0101;
    step_check("midrst_src");
    @(negedge clk);
    step_check("midrst_exec");
    exp_q.delete();
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_now", 32'(observe()), 32'd0);
    @(negedge clk);
    chk("midrst_out_held", 32'(observe()), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_release_f1", 32'(observe()), 32'(v_fetch1()));
    run_instr(4'b0011, 1'b1);

    // Random opcode soak.
    d0 = n_done;
    f0 = n_f1;
    c0 = n_cyc;
    while (n_cyc - c0 < 10000) run_instr(4'($urandom_range(0, 15)), 1'b1);
    o = observe();
    chk("soak_end_f1", 32'(o), 32'(v_fetch1()));
    if (o.mr && o.LSEn) n_f1++;
    chk("soak_done_vs_f1", 32'(n_done - d0), 32'(n_f1 - f0 - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the accumulator datapath.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port toCU, input, 4 bits: opcode nibble, taken combinationally from memory output bits [7:4].
REQ-005 SHALL have 1-bit outputs pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn, selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn: datapath strobes and selects.
REQ-006 SHALL have outputs selAddressAC and selData, 2 bits each: AC-index select and AC write-data select.
REQ-007 SHALL have output operation, 3 bits: ALU function.
REQ-008 SHALL have output instrDone, 1 bit: one-cycle pulse in the last state of every instruction.

Function
REQ-009 SHALL be a Moore FSM; every output SHALL be decoded from the state register and the latched opcode register op[3:0], and any output not listed for a state SHALL be 0.
REQ-010 SHALL use the datapath select encodings selAddress 0=PC/1=RI, selPC 0=PC+1/1=RI, selAddressAC 0=DI[4:3]/1=LS[1:0]/2=LS[3:2], selData 0=word/1=result/2=data, and selALUsrc 0=dataReg/1=wordReg.
REQ-011 SHALL implement FETCH1 as: selAddress=0, mr=1, LSEn=1, pcEn=1, with op<=toCU; next state is determined by the rules below.
REQ-012 SHALL implement the ALU-op path (op[3]=1, one byte): ALU_SRC (selAddressAC=2, dataRegEn=1), then ALU_EXEC (selAddressAC=1, selALUsrc=0, operation=op[2:0], resultRegEn=CEn=ZEn=NEn=1), then ALU_WB (selAddressAC=1, selData=1, enb=1, instrDone=1), then FETCH1.
REQ-013 SHALL implement SETD (op[3:1]=011, one byte) as the single state SETD (DIEn=1, instrDone=1), then FETCH1.
REQ-014 SHALL send op[3:1] of 000, 001 and 010 to FETCH2 (selAddress=0, mr=1, RSEn=1, pcEn=1).
REQ-015 SHALL implement LOAD (000) as: MEM_RD (selAddress=1, mr=1, wordRegEn=1), then LD_WB (selAddressAC=0, selData=0, enb=1, instrDone=1).
REQ-016 SHALL implement STORE (001) as: ST_RD (selAddressAC=0, dataRegEn=1), then ST_WR (selAddress=1, mw=1, instrDone=1).
REQ-017 SHALL implement JMP (010) as the single state JUMP (selPC=1, pcEn=1, instrDone=1).
REQ-018 SHALL return to FETCH1 after the final state of every instruction.
REQ-019 SHALL give instruction latencies in clocks of: ALU 4, SETD 2, LOAD 4, STORE 4, JMP 3.
REQ-020 SHALL never assert mr and mw in the same cycle.
REQ-021 SHALL assert at most one of LSEn, RSEn and wordRegEn per cycle.
REQ-022 SHALL assert pcEn in exactly two cases: the fetch states, and JUMP.
REQ-023 SHALL leave op unchanged in every state except FETCH1.
REQ-024 SHALL treat toCU values containing X/Z in FETCH1 as don't-care and SHALL NOT lock up on any 4-bit opcode value; all 16 values are decoded.
REQ-025 SHALL force any illegal state encoding to FETCH1 on the next clock.

Reset
REQ-026 SHALL, while reset=1, asynchronously set state=FETCH1 and op=4'b0000 and force every output to 0, including instrDone.
REQ-027 SHALL, on the first rising clk edge after reset falls, execute FETCH1; reset asserted mid-instruction SHALL abandon it with no further strobes.

Structure
REQ-028 SHALL take the state encoding, opcode constants (LOAD, STORE, JMP, SETD, ALU bit) and select encodings from the shared package cu_pkg.
REQ-029 SHALL contain one sub-module, cu_decode: purely combinational state+op to output-vector decode; the state register and next-state logic stay in control_unit.

Verification
REQ-030 SHALL cover reset mid-ALU_EXEC: assert reset -> all outputs 0 the same cycle; release -> FETCH1 strobes (mr=1, LSEn=1, pcEn=1) on the next cycle.
REQ-031 SHALL cover toCU=4'b1010 in FETCH1: -> ALU_SRC, ALU_EXEC with operation=3'b010 and C/Z/N enables, ALU_WB with enb=1 and selData=1; instrDone high on cycle 4 only.
REQ-032 SHALL cover toCU=4'b0000 (LOAD): -> FETCH2, MEM_RD (selAddress=1, mr=1, wordRegEn=1), LD_WB (enb=1, selAddressAC=0); 4 clocks total.
REQ-033 SHALL cover toCU=4'b0010 (STORE): -> ST_WR asserts mw=1 with selAddress=1, and mr=0 in that cycle.
REQ-034 SHALL cover toCU=4'b0100 (JMP) followed by 4'b0110 (SETD): -> JUMP with selPC=1 and pcEn=1, then SETD with DIEn=1; instrDone pulses exactly twice.
REQ-035 SHALL cover all 16 toCU values randomly for 10k cycles: -> no mr&mw, no stuck state, and an instrDone count equal to the number of FETCH1 entries minus one.
